irq_injector: RTL
=================

Name: irq_injector

Overview:
- Synthesizable, parametrised interrupt stimulus generator for the pipelined MIPS CPU benches.
- Watches the CPU's committed-PC output `addr`. Each of N_CH independent channels asserts its interrupt line a programmed delay after `addr` hits that channel's trigger address.
- Per channel: pulse width, repeat count, and pulse-vs-acknowledge mode.
- Its `irq` bus drives the CPU's HWInt inputs in place of hand-written bench stimulus.

Parameters:
- N_CH, 6, number of interrupt channels (maps to HWInt[7:2]).
- AW, 32, width of `addr` and of the trigger-address registers.
- CW, 8, width of the delay, width and repeat counters.
- CHW, 3, width of the channel-select field; must satisfy 2^CHW >= N_CH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- addr  in  AW  CPU PC/macro-PC under observation.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CHW  channel index for the write; values >= N_CH are ignored.
- cfg_sel  in  2  register select: 0=trig_addr, 1=delay, 2=width, 3=ctrl.
- cfg_wdata  in  AW  write data. ctrl layout: [0]=enable, [1]=mode (0 pulse, 1 ack), [CW+1:2]=repeat.
- irq_ack  in  N_CH  per-channel acknowledge; used in ack mode only.
- irq  out  N_CH  registered interrupt lines.
- busy  out  N_CH  channel is in DLY or ASRT.
- irq_any  out  1  OR of `irq`, registered.

Behaviour:
- Reset: `irq`, `busy` and `irq_any` = 0. All channels go to IDLE. All config registers = 0 (trig_addr, delay, width, enable, mode, repeat).
- Per-channel FSM states: IDLE, ARMED, DLY, ASRT, DONE.
- IDLE -> ARMED: enable written 1. On entry, clear the `seen_miss` flag and load `rem` = repeat.
- ARMED:
  - `seen_miss` sets on any cycle with addr != trig_addr.
  - A match (addr == trig_addr with `seen_miss` = 1, or the first match after entering ARMED from IDLE) moves the channel to DLY and loads the delay counter with `delay`.
  - Net effect: a single PC dwell of several cycles fires only once.
- DLY: decrement each cycle. When the counter is 0, go to ASRT and load the width counter with max(width, 1).
- Cycle-level timing: match sampled at edge t gives irq = 1 from edge t+delay+1. delay = 0 gives irq high on the edge after the match.
- ASRT, pulse mode: irq = 1 for exactly max(width, 1) cycles, then irq = 0.
- ASRT, ack mode: `width` is ignored. irq stays 1 until irq_ack is sampled high while irq = 1; irq drops on that same edge.
- End of pulse or ack:
  - repeat == 0 (infinite): go to ARMED with `seen_miss` = 0.
  - otherwise decrement `rem`; if the result is 0 go to DONE, else go to ARMED with `seen_miss` = 0.
- DONE: irq = 0. The channel leaves DONE only via an enable 0->1 rewrite.
- Matches in DLY, ASRT or DONE are ignored. No queuing.
- Writing enable = 0 from any state: IDLE on the next edge, irq = 0 on that edge. This has priority over ack and counter expiry in the same cycle.
- trig_addr, delay, width or mode writes while not IDLE: the register updates immediately. Running counters are unaffected; new values apply from the next load.
- Ack on a channel in pulse mode, or ack while irq = 0: ignored.
- Channels are fully independent. Several channels may share a trig_addr and fire on the same cycle.
- Counters are CW-bit unsigned. delay = 2^CW-1 is valid and must not wrap.
- irq_any lags irq by 0 cycles: it is computed from the next-state irq and registered alongside it.
- Reset asserted mid-operation: every channel returns to IDLE and all config is lost.

Test Plan:
- Ch0: trig=0x0000301C, delay=5, width=6, repeat=1, pulse mode. addr=0x301C at edge t -> irq[0] high edges t+6..t+11, low at t+12, channel in DONE, no refire when 0x301C recurs.
- Ch1: delay=0, width=0, repeat=0 (infinite). addr toggles 0x3000/0x3004 every 4 cycles with trig=0x3004 -> 1-cycle pulse on the edge after each 0x3004 entry. Holding 0x3004 for 10 cycles -> only one pulse.
- Ch2 ack mode: trig=0x3010, delay=2, ack raised 7 cycles after irq rises -> irq[2] high for exactly 7 cycles. Ack pulsed before the trigger -> no effect.
- Ch3 abort: enable=0 written in the 3rd ASRT cycle -> irq[3]=0 next edge, busy[3]=0. Re-enable then match -> full pulse again.
- Simultaneous: ch0 and ch4 share trig=0x3020 with different delays (1, 3) -> irq=6'b000001 then 6'b010001 as windows overlap; irq_any continuous.
- Reset: reset=0 mid-DLY on all channels -> irq=0, busy=0, configs zero. A subsequent addr match produces nothing until reprogrammed.

Source files
------------

// File: rtl/irq_injector_if.sv
// Bus bundle for irq_injector: observed PC, configuration write port,
// per-channel acknowledges and the generated interrupt/status lines.
interface irq_injector_if #(
   parameter int N_CH = 6,
   parameter int AW   = 32,
   parameter int CHW  = 3
);
   logic [AW-1:0]   addr;
   logic            cfg_we;
   logic [CHW-1:0]  cfg_ch;
   logic [1:0]      cfg_sel;
   logic [AW-1:0]   cfg_wdata;
   logic [N_CH-1:0] irq_ack;
   logic [N_CH-1:0] irq;
   logic [N_CH-1:0] busy;
   logic            irq_any;

   modport master (
      output addr, cfg_we, cfg_ch, cfg_sel, cfg_wdata, irq_ack,
      input  irq, busy, irq_any
   );

   modport slave (
      input  addr, cfg_we, cfg_ch, cfg_sel, cfg_wdata, irq_ack,
      output irq, busy, irq_any
   );
endinterface

// File: rtl/irq_injector.sv
// Interrupt stimulus generator: each channel raises its irq line a programmed
// delay after the observed PC hits its trigger address, for a width or until acked.
module irq_injector #(
   parameter int N_CH = 6,
   parameter int AW   = 32,
   parameter int CW   = 8,
   parameter int CHW  = 3
) (
   input logic           clk,
   input logic           reset,
   irq_injector_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DLY,
      S_ASRT,
      S_DONE
   } state_e;

   logic [N_CH-1:0] irq_d, irq_q;
   logic [N_CH-1:0] busy_d, busy_q;
   logic            irq_any_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_e         state_q, state_d;
      logic [AW-1:0]  trig_q, trig_d;
      logic [CW-1:0]  dly_q, dly_d;
      logic [CW-1:0]  wid_q, wid_d;
      logic [CW-1:0]  rpt_q, rpt_d;
      logic [CW-1:0]  cnt_q, cnt_d;
      logic [CW-1:0]  rem_q, rem_d;
      logic           en_q, en_d;
      logic           mode_q, mode_d;
      logic           miss_q, miss_d;
      logic           first_q, first_d;
      logic           wr, wr_ctrl, hit, pulse_end;
      logic [CW-1:0]  wid_eff;

      assign wr        = bus.cfg_we && (bus.cfg_ch == CHW'(g));
      assign wr_ctrl   = wr && (bus.cfg_sel == 2'd3);
      assign hit       = (bus.addr == trig_q);
      assign wid_eff   = (wid_q == '0) ? CW'(1) : wid_q;
      assign pulse_end = mode_q ? bus.irq_ack[g] : (cnt_q == CW'(1));

      always_comb begin
         trig_d  = trig_q;
         dly_d   = dly_q;
         wid_d   = wid_q;
         rpt_d   = rpt_q;
         en_d    = en_q;
         mode_d  = mode_q;
         state_d = state_q;
         cnt_d   = cnt_q;
         rem_d   = rem_q;
         miss_d  = miss_q;
         first_d = first_q;

         if (wr) begin
            case (bus.cfg_sel)
               2'd0: trig_d = bus.cfg_wdata;
               2'd1: dly_d  = bus.cfg_wdata[CW-1:0];
               2'd2: wid_d  = bus.cfg_wdata[CW-1:0];
               default: begin
                  en_d   = bus.cfg_wdata[0];
                  mode_d = bus.cfg_wdata[1];
                  rpt_d  = bus.cfg_wdata[CW+1:2];
               end
            endcase
         end

         case (state_q)
            S_IDLE: begin
               if (wr_ctrl && bus.cfg_wdata[0]) begin
                  state_d = S_ARMED;
                  miss_d  = 1'b0;
                  first_d = 1'b1;
                  rem_d   = bus.cfg_wdata[CW+1:2];
               end
            end
            // First match after arming fires at once; later ones need a miss in between.
            S_ARMED: begin
               if (hit && (miss_q || first_q)) begin
                  state_d = S_DLY;
                  cnt_d   = dly_q;
                  first_d = 1'b0;
               end else if (!hit) begin
                  miss_d = 1'b1;
               end
            end
            S_DLY: begin
               if (cnt_q == '0) begin
                  state_d = S_ASRT;
                  cnt_d   = wid_eff;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_ASRT: begin
               if (pulse_end) begin
                  miss_d  = 1'b0;
                  first_d = 1'b0;
                  if (rem_q == '0) begin
                     state_d = S_ARMED;
                  end else begin
                     rem_d   = rem_q - CW'(1);
                     state_d = (rem_q == CW'(1)) ? S_DONE : S_ARMED;
                  end
               end else if (!mode_q) begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase

         // Disable wins over every other transition in the same cycle.
         if (wr_ctrl && !bus.cfg_wdata[0]) begin
            state_d = S_IDLE;
         end
      end

      assign irq_d[g]  = (state_d == S_ASRT);
      assign busy_d[g] = (state_d == S_DLY) || (state_d == S_ASRT);

      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q <= S_IDLE;
            trig_q  <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            rpt_q   <= '0;
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            miss_q  <= 1'b0;
            first_q <= 1'b0;
         end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            rpt_q   <= rpt_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            miss_q  <= miss_d;
            first_q <= first_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_q     <= '0;
         busy_q    <= '0;
         irq_any_q <= 1'b0;
      end else begin
         irq_q     <= irq_d;
         busy_q    <= busy_d;
         irq_any_q <= |irq_d;
      end
   end

   assign bus.irq     = irq_q;
   assign bus.busy    = busy_q;
   assign bus.irq_any = irq_any_q;

endmodule
